friet_permutation_stream_controller: RTL and testbench
======================================================

Name: friet_permutation_stream_controller

Overview:
- Host-facing sequencer for friet_permutation_n_rounds_no_communication.
- Accepts a 384-bit Friet state as a valid/ready stream of BUFFER_LENGTH-bit words and shifts it into the core.
- Starts the permutation, waits for completion, then streams the permuted state back out as valid/ready words.
- Owns every core control strobe. The core's shift buffer is driven only by this block.

Parameters:
- BUFFER_LENGTH, 32, word width. Must divide 384; legal values are 8, 16, 32, 64, 128.
- WORDS, 384/BUFFER_LENGTH, localparam: words per state (12 at default).

Ports:
- clk  input  1  clock
- aresetn  input  1  asynchronous active-low reset
- din  input  BUFFER_LENGTH  input word. Word 0 is state bits [BL-1:0], i.e. the low word of a.
- din_valid  input  1  din holds a word
- din_ready  output  1  controller accepts din this cycle
- dout  output  BUFFER_LENGTH  output word. Word 0 is state bits [BL-1:0].
- dout_valid  output  1  dout holds a word
- dout_ready  input  1  host takes dout this cycle
- busy  output  1  high in every state except LOAD with word count 0
- core_start_enable  output  1  to core start_enable
- core_state_buffer_in_enabled  output  1  to core state_buffer_in_enabled
- core_state_buffer_in  output  BUFFER_LENGTH  to core state_buffer_in; equals din
- core_state_buffer_out_enabled  output  1  to core state_buffer_out_enabled
- core_state_buffer_low  input  BUFFER_LENGTH  core state_buffer[BL-1:0]
- core_free  input  1  from core
- core_finish  input  1  from core; one-cycle pulse

Behaviour:
- Clock and reset: one clock, clk. Reset aresetn is asynchronous, active-low.
- Reset values: state=LOAD, word counter=0, din_ready=0, dout_valid=0, busy=0, core_start_enable=0, all core enables 0.
- The core shares aresetn, so a reset mid-operation aborts both blocks. Partial loads and unloads are discarded; the core buffer contents are don't-care.
- Word counter is 4 bits wide (log2(WORDS) rounded up). It wraps to 0 only by explicit clear.

State LOAD:
- din_ready = core_free.
- On din_valid && din_ready: core_state_buffer_in_enabled=1 in the same cycle, and the counter increments.
- When the accepted word is word WORDS-1: clear the counter and go to START.
- din_valid low stalls the load indefinitely with no timeout.

State START:
- core_start_enable=1 for exactly this one cycle; din_ready=0.
- Next state is WAIT.

State WAIT:
- All host handshakes are low.
- core_finish=1 moves the FSM to UNLOAD.
- A core_finish seen in any other state is ignored.

State UNLOAD:
- dout = core_state_buffer_low (combinational); dout_valid=1.
- On dout_valid && dout_ready: core_state_buffer_out_enabled=1 in the same cycle, and the counter increments.
- After word WORDS-1 is taken: clear the counter and go to LOAD.
- The core rotates the buffer, so after WORDS words it holds the permuted state again. This is benign.

Handshake rules:
- din_ready and dout_valid are never high in the same cycle.
- din_ready is low in the cycle after the last input word is accepted. This guarantees a gap before START.
- Back-to-back operation: the first word of the next state may be accepted in the cycle after the last output word.
- Controller overhead is 1 cycle (START) + 1 cycle (WAIT→UNLOAD decision) on top of core latency.
- Full cycle with COMBINATIONAL_ROUNDS=1 and an always-ready host: 12 load + 1 start + 24 core + 1 + 12 unload.

Optional Feature:
- Macro: FRIET_STREAM_CTRL_PERM_COUNT_EN.
- When defined:
  - Adds output perm_count [15:0], reset 0.
  - Increments on each WAIT→UNLOAD transition and saturates at 16'hFFFF.
  - Adds input perm_count_clear, which zeroes the count synchronously. Clear wins over a simultaneous increment.
- When undefined: neither port exists and the block behaves identically otherwise.

Test Plan:
- Reset then idle, with din_valid=0 and the core model attached:
  - busy=0, din_ready=1, dout_valid=0, all core strobes 0.
- All-zero state:
  - Stimulus: stream 12 words of 32'h0, host always ready, COMBINATIONAL_ROUNDS=1.
  - core_start_enable pulses exactly once, 1 cycle after word 11.
  - 12 output words appear and match the software Friet permutation of zero, word 0 first.
- Stall coverage:
  - Stimulus: random din_valid gaps (about 50% duty) plus random dout_ready backpressure, state words 32'h00000000..32'h0000000B.
  - Output matches the reference permutation.
  - No word is duplicated or dropped.
  - core_state_buffer_out_enabled count equals 12.
- Back-to-back: three consecutive states.
  - The first input word of state n+1 is accepted in the cycle after the last output word of state n.
  - Each output matches its own reference.
- Mid-operation reset:
  - Stimulus: assert aresetn=0 during WAIT, then release.
  - All outputs return to reset values asynchronously.
  - A fresh 12-word load then produces a correct result.
- With FRIET_STREAM_CTRL_PERM_COUNT_EN:
  - After 3 permutations, perm_count=3.
  - Clear asserted in the same cycle as the 4th WAIT→UNLOAD gives perm_count=0.
  - A preloaded 16'hFFFF stays at 16'hFFFF after a further permutation.

Source files
------------

// File: rtl/friet_permutation_stream_controller_if.sv
// friet_permutation_stream_controller_if
// Bundles the host word stream and the core control/observation signals
// that surround friet_permutation_stream_controller.
//   slave  : the controller's view
//   master : the environment's view (host plus permutation core)
interface friet_permutation_stream_controller_if #(
    parameter int BUFFER_LENGTH = 32
);
    // Host input stream
    logic [BUFFER_LENGTH-1:0] din;
    logic                     din_valid;
    logic                     din_ready;

    // Host output stream
    logic [BUFFER_LENGTH-1:0] dout;
    logic                     dout_valid;
    logic                     dout_ready;

    // Status
    logic                     busy;

    // Core control strobes and observation
    logic                     core_start_enable;
    logic                     core_state_buffer_in_enabled;
    logic [BUFFER_LENGTH-1:0] core_state_buffer_in;
    logic                     core_state_buffer_out_enabled;
    logic [BUFFER_LENGTH-1:0] core_state_buffer_low;
    logic                     core_free;
    logic                     core_finish;

    modport slave (
        input  din,
        input  din_valid,
        input  dout_ready,
        input  core_state_buffer_low,
        input  core_free,
        input  core_finish,
        output din_ready,
        output dout,
        output dout_valid,
        output busy,
        output core_start_enable,
        output core_state_buffer_in_enabled,
        output core_state_buffer_in,
        output core_state_buffer_out_enabled
    );

    modport master (
        output din,
        output din_valid,
        output dout_ready,
        output core_state_buffer_low,
        output core_free,
        output core_finish,
        input  din_ready,
        input  dout,
        input  dout_valid,
        input  busy,
        input  core_start_enable,
        input  core_state_buffer_in_enabled,
        input  core_state_buffer_in,
        input  core_state_buffer_out_enabled
    );
endinterface

// File: rtl/friet_permutation_stream_controller.sv
// friet_permutation_stream_controller
// Host-facing sequencer for the Friet permutation core. A 384-bit state is
// accepted as BUFFER_LENGTH-bit words (word 0 = state bits [BL-1:0]) and
// shifted into the core, the permutation is started, and once the core
// reports completion the permuted state is streamed back out, word 0 first.
// The controller is the only driver of the core's shift-buffer strobes.
//
// Optional build macro: FRIET_STREAM_CTRL_PERM_COUNT_EN
//   Adds perm_count[15:0] (saturating count of completed permutations) and
//   perm_count_clear (synchronous clear, wins over a same-cycle increment).
module friet_permutation_stream_controller #(
    parameter int BUFFER_LENGTH = 32
) (
    input  logic        clk,
    input  logic        aresetn,
`ifdef FRIET_STREAM_CTRL_PERM_COUNT_EN
    input  logic        perm_count_clear,
    output logic [15:0] perm_count,
`endif
    friet_permutation_stream_controller_if.slave bus
);

    localparam int STATE_BITS = 384;
    localparam int WORDS      = STATE_BITS / BUFFER_LENGTH;
    localparam int CNT_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_START  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_UNLOAD = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] word_cnt;
    logic             alive;

    logic din_ready;
    logic dout_valid;
    logic in_fire;
    logic out_fire;
    logic last_word;

    // Host handshakes and core strobes decoded from the current state.
    always_comb begin
        din_ready  = alive && (state == ST_LOAD) && bus.core_free;
        dout_valid = (state == ST_UNLOAD);
        in_fire    = din_ready && bus.din_valid;
        out_fire   = dout_valid && bus.dout_ready;
        last_word  = (word_cnt == LAST_WORD);
    end

    assign bus.din_ready                     = din_ready;
    assign bus.dout_valid                    = dout_valid;
    assign bus.dout                          = bus.core_state_buffer_low;
    assign bus.core_state_buffer_in          = bus.din;
    assign bus.core_state_buffer_in_enabled  = in_fire;
    assign bus.core_state_buffer_out_enabled = out_fire;
    assign bus.core_start_enable             = (state == ST_START);
    assign bus.busy                          = !((state == ST_LOAD) && (word_cnt == '0));

    // Next-state decode: LOAD -> START -> WAIT -> UNLOAD -> LOAD.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            ST_LOAD:   if (in_fire && last_word)  state_next = ST_START;
            ST_START:                             state_next = ST_WAIT;
            ST_WAIT:   if (bus.core_finish)       state_next = ST_UNLOAD;
            ST_UNLOAD: if (out_fire && last_word) state_next = ST_LOAD;
            default:                              state_next = ST_LOAD;
        endcase
    end

    // State register; alive keeps din_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge aresetn) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!aresetn) begin
            state <= ST_LOAD;
            alive <= 1'b0;
        end else begin
            state <= state_next;
            alive <= 1'b1;
        end
    end

    // Word counter shared by load and unload; cleared after the last word.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            word_cnt <= '0;
        end else if (in_fire || out_fire) begin
            if (last_word) begin
                word_cnt <= '0;
            end else begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

`ifdef FRIET_STREAM_CTRL_PERM_COUNT_EN
    logic [15:0] perm_cnt;
    logic        perm_done;

    assign perm_done  = (state == ST_WAIT) && bus.core_finish;
    assign perm_count = perm_cnt;

    // Saturating permutation counter; clear has priority over increment.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            perm_cnt <= 16'd0;
        end else if (perm_count_clear) begin
            perm_cnt <= 16'd0;
        end else if (perm_done && (perm_cnt != 16'hFFFF)) begin
            perm_cnt <= perm_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_friet_permutation_stream_controller.sv
// tb_friet_permutation_stream_controller
// Drives friet_permutation_stream_controller with a behavioural Friet-PC core
// model attached. Expected output words are produced by a software permutation
// and queued when each state is issued; a negedge monitor pops and compares
// every word the controller hands to the host.
// Optional build macro: FRIET_STREAM_CTRL_PERM_COUNT_EN
`timescale 1ns/1ps
module tb_friet_permutation_stream_controller;

    localparam int BL       = 32;
    localparam int WORDS    = 384 / BL;
    localparam int CORE_LAT = 24;
    localparam int TIMEOUT  = 2000;

    localparam logic [31:0] RC [0:CORE_LAT-1] = '{
        32'h00001111, 32'h11100000, 32'h00001101, 32'h10100000,
        32'h00000101, 32'h10110000, 32'h00000110, 32'h11000000,
        32'h00001001, 32'h00100000, 32'h00100001, 32'h10010000,
        32'h00000011, 32'h10000001, 32'h00010100, 32'h01001000,
        32'h00001010, 32'h00110000, 32'h00100110, 32'h01010000,
        32'h00000111, 32'h11010000, 32'h00011000, 32'h10001001
    };

    logic clk     = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    friet_permutation_stream_controller_if #(.BUFFER_LENGTH(BL)) bus ();

`ifdef FRIET_STREAM_CTRL_PERM_COUNT_EN
    logic        perm_count_clear = 1'b0;
    logic [15:0] perm_count;
`endif

    friet_permutation_stream_controller #(.BUFFER_LENGTH(BL)) dut (
        .clk              (clk),
        .aresetn          (aresetn),
`ifdef FRIET_STREAM_CTRL_PERM_COUNT_EN
        .perm_count_clear (perm_count_clear),
        .perm_count       (perm_count),
`endif
        .bus              (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- software Friet-PC permutation ----------------
    function automatic logic [127:0] rotl(input logic [127:0] x, input int n);
        return (x << n) | (x >> (128 - n));
    endfunction

    function automatic logic [383:0] friet_perm(input logic [383:0] s);
        logic [127:0] a, b, c, t, old_a;
        a = s[127:0];
        b = s[255:128];
        c = s[383:256];
        for (int r = 0; r < CORE_LAT; r++) begin
            c     = c ^ {96'd0, RC[r]};
            t     = a ^ b ^ c;
            old_a = a;
            b     = c;
            c     = old_a;
            a     = t;
            b     = b ^ rotl(c, 1);
            c     = c ^ rotl(b, 80);
            b     = a ^ b ^ c;
            a     = a ^ (rotl(b, 36) & rotl(c, 67));
        end
        return {c, b, a};
    endfunction

    // ---------------- behavioural core model ----------------
    logic [383:0] core_buf;
    int           core_cnt;
    logic         core_fin;

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            core_buf <= '0;
            core_cnt <= 0;
            core_fin <= 1'b0;
        end else begin
            core_fin <= 1'b0;
            if (bus.core_state_buffer_in_enabled)
                core_buf <= {bus.core_state_buffer_in, core_buf[383:BL]};
            else if (bus.core_state_buffer_out_enabled)
                core_buf <= {core_buf[BL-1:0], core_buf[383:BL]};
            if (bus.core_start_enable && core_cnt == 0) begin
                core_cnt <= CORE_LAT;
            end else if (core_cnt != 0) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1) begin
                    core_buf <= friet_perm(core_buf);
                    core_fin <= 1'b1;
                end
            end
        end
    end

    assign bus.core_state_buffer_low = core_buf[BL-1:0];
    assign bus.core_free             = (core_cnt == 0) && !core_fin;
    assign bus.core_finish           = core_fin;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard / monitor ----------------
    logic [BL-1:0] exp_q[$];
    int  in_idx       = 0;
    int  out_idx      = 0;
    int  last_in_cyc  = 0;
    int  last_out_cyc = 0;
    int  start_cnt    = 0;
    int  outen_cnt    = 0;
    int  b2b_hits     = 0;
    bit  b2b_mode     = 1'b0;
    bit  b2b_armed    = 1'b0;
    bit  rand_ready   = 1'b0;

    initial begin
        logic [BL-1:0] e;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                in_idx    = 0;
                out_idx   = 0;
                b2b_armed = 1'b0;
            end else begin
                check("ready_valid_exclusive", 64'(bus.din_ready & bus.dout_valid), 64'd0);
                check("in_strobe", 64'(bus.core_state_buffer_in_enabled),
                      64'(bus.din_valid & bus.din_ready));
                check("out_strobe", 64'(bus.core_state_buffer_out_enabled),
                      64'(bus.dout_valid & bus.dout_ready));
                if (bus.core_state_buffer_out_enabled) outen_cnt++;
                if (bus.core_start_enable) begin
                    start_cnt++;
                    check("start_after_last_word", 64'(cyc), 64'(last_in_cyc + 1));
                end
                if (bus.din_valid && bus.din_ready) begin
                    check("core_buffer_in", 64'(bus.core_state_buffer_in), 64'(bus.din));
                    if (in_idx == 0 && b2b_armed) begin
                        b2b_hits++;
                        check("b2b_first_word_cycle", 64'(cyc), 64'(last_out_cyc + 1));
                        b2b_armed = 1'b0;
                    end
                    if (in_idx == WORDS - 1) begin
                        last_in_cyc = cyc;
                        in_idx = 0;
                    end else begin
                        in_idx++;
                    end
                end
                if (bus.dout_valid && bus.dout_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 64'(bus.dout), 64'hDEAD_0000_0000_0000);
                    end else begin
                        e = exp_q.pop_front();
                        check("dout_word", 64'(bus.dout), 64'(e));
                    end
                    if (out_idx == WORDS - 1) begin
                        out_idx = 0;
                        last_out_cyc = cyc;
                        if (b2b_mode) b2b_armed = 1'b1;
                    end else begin
                        out_idx++;
                    end
                end
            end
        end
    end

    // Host sink: always ready or random backpressure.
    initial begin
        bus.dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    int n_loads   = 0;
    int n_aborted = 0;

    task automatic send_state(input logic [383:0] s, input bit gaps);
        logic [383:0] p;
        int           waited;
        bit           acc;
        p = friet_perm(s);
        for (int i = 0; i < WORDS; i++) exp_q.push_back(p[i*BL +: BL]);
        for (int i = 0; i < WORDS; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) begin
                    bus.din_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            bus.din       = s[i*BL +: BL];
            bus.din_valid = 1'b1;
            waited = 0;
            acc    = 1'b0;
            while (!acc && waited < TIMEOUT) begin
                @(negedge clk);
                acc = bus.din_ready;
                @(posedge clk);
                #1;
                waited++;
            end
            if (!acc) begin
                check("din_accept_timeout", 64'd0, 64'd1);
                bus.din_valid = 1'b0;
                return;
            end
        end
        bus.din_valid = 1'b0;
        n_loads++;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < TIMEOUT) begin
            @(posedge clk);
            n++;
        end
        check("drain_remaining_words", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [383:0] rand_state();
        logic [383:0] s;
        for (int i = 0; i < 12; i++) s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    initial begin
        logic [383:0] s;
        int           st;
        int           n;
        int           outen_before;

        bus.din       = '0;
        bus.din_valid = 1'b0;

        // Reset values while held in reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_din_ready", 64'(bus.din_ready), 64'd0);
        check("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_start", 64'(bus.core_start_enable), 64'd0);
        aresetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Idle after reset
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_din_ready", 64'(bus.din_ready), 64'd1);
        check("idle_dout_valid", 64'(bus.dout_valid), 64'd0);
        check("idle_strobes", {61'd0, bus.core_start_enable, bus.core_state_buffer_in_enabled,
                               bus.core_state_buffer_out_enabled}, 64'd0);

        // All-zero state, host always ready
        rand_ready = 1'b0;
        send_state('0, 1'b0);
        check("load_busy", 64'(bus.busy), 64'd1);
        wait_drain();
        check("zero_start_pulses", 64'(start_cnt), 64'd1);

        // Stall coverage: input gaps and output backpressure
        for (int i = 0; i < 12; i++) s[i*32 +: 32] = 32'(i);
        outen_before = outen_cnt;
        rand_ready = 1'b1;
        send_state(s, 1'b1);
        wait_drain();
        rand_ready = 1'b0;
        check("stall_out_strobes", 64'(outen_cnt - outen_before), 64'(WORDS));

        // Back-to-back: three consecutive states
        b2b_mode = 1'b1;
        for (int k = 0; k < 3; k++) send_state(rand_state(), 1'b0);
        wait_drain();
        b2b_mode  = 1'b0;
        b2b_armed = 1'b0;
        check("b2b_transitions_seen", 64'(b2b_hits), 64'd2);

        // Mid-operation reset during WAIT
        st = start_cnt;
        send_state(rand_state(), 1'b0);
        n = 0;
        while (start_cnt == st && n < TIMEOUT) begin
            @(posedge clk);
            n++;
        end
        check("midrst_start_seen", 64'(start_cnt), 64'(st + 1));
        repeat (5) @(posedge clk);
        #2;
        check("wait_busy", 64'(bus.busy), 64'd1);
        check("wait_handshakes", {62'd0, bus.din_ready, bus.dout_valid}, 64'd0);
        aresetn = 1'b0;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_din_ready", 64'(bus.din_ready), 64'd0);
        check("midrst_dout_valid", 64'(bus.dout_valid), 64'd0);
        check("midrst_strobes", {61'd0, bus.core_start_enable, bus.core_state_buffer_in_enabled,
                                 bus.core_state_buffer_out_enabled}, 64'd0);
        exp_q.delete();
        n_aborted++;
        @(posedge clk);
        #2;
        aresetn = 1'b1;
        send_state(rand_state(), 1'b0);
        wait_drain();

`ifdef FRIET_STREAM_CTRL_PERM_COUNT_EN
        perm_count_clear = 1'b1;
        @(posedge clk);
        #1;
        perm_count_clear = 1'b0;
        check("pc_cleared", 64'(perm_count), 64'd0);
        for (int k = 0; k < 3; k++) begin
            send_state(rand_state(), 1'b0);
            wait_drain();
        end
        check("pc_three", 64'(perm_count), 64'd3);

        send_state(rand_state(), 1'b0);
        n = 0;
        while (!core_fin && n < TIMEOUT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("pc_finish_seen", 64'(core_fin), 64'd1);
        perm_count_clear = 1'b1;
        @(posedge clk);
        #1;
        perm_count_clear = 1'b0;
        wait_drain();
        check("pc_clear_wins", 64'(perm_count), 64'd0);

        force dut.perm_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.perm_cnt;
        send_state(rand_state(), 1'b0);
        wait_drain();
        check("pc_saturate", 64'(perm_count), 64'hFFFF);
`endif

        check("start_total", 64'(start_cnt), 64'(n_loads));
        check("out_strobe_total", 64'(outen_cnt), 64'(WORDS * (n_loads - n_aborted)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
